// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
// States and default parameter values are used by switch_debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        CHECK_HI,
        STABLE_HI,
        CHECK_LO
    } db_state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sync_chain.sv
// Reset-to-zero flop chain that brings an asynchronous level into the clk domain.
// The output is the last stage of the chain.
module sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronizer followed by a qualify-then-accept FSM.
// Optional rise/fall pulse outputs exist only when DEBOUNCE_EDGE_PULSE_EN is defined.
//
// state     | meaning
// STABLE_LO | accepted level is 0, waiting for s=1
// CHECK_HI  | candidate 1 is being qualified
// STABLE_HI | accepted level is 1, waiting for s=0
// CHECK_LO  | candidate 0 is being qualified
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic busy
`ifdef DEBOUNCE_EDGE_PULSE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    db_state_t        state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             dout_next;

    sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= STABLE_LO;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            dout  <= dout_next;
        end
    end

    // Entering a CHECK state counts as the first stable sample.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        dout_next  = dout;
        unique case (state)
            STABLE_LO: begin
                if (s) begin
                    next_state = CHECK_HI;
                    cnt_next   = CNT_W'(1);
                end
            end
            CHECK_HI: begin
                if (!s) begin
                    next_state = STABLE_LO;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = STABLE_HI;
                    cnt_next   = '0;
                    dout_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    next_state = CHECK_LO;
                    cnt_next   = CNT_W'(1);
                end
            end
            CHECK_LO: begin
                if (s) begin
                    next_state = STABLE_HI;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    next_state = STABLE_LO;
                    cnt_next   = '0;
                    dout_next  = 1'b0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                next_state = STABLE_LO;
                cnt_next   = '0;
                dout_next  = 1'b0;
            end
        endcase
    end

    assign busy = (state == CHECK_HI) || (state == CHECK_LO);

`ifdef DEBOUNCE_EDGE_PULSE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= dout_next & ~dout;
            fall <= ~dout_next & dout;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed table, bounce/latency sequence,
// and randomized din checked against a run-length reference model on three configurations.
module tb_switch_debouncer;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b1;
    logic [N-1:0] dout, busy;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic [N-1:0] rise, fall;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    switch_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut0 (
        .clk(clk), .rst(rst), .din(din), .dout(dout[0]), .busy(busy[0])
`ifdef DEBOUNCE_EDGE_PULSE_EN
        , .rise(rise[0]), .fall(fall[0])
`endif
    );

    switch_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst), .din(din), .dout(dout[1]), .busy(busy[1])
`ifdef DEBOUNCE_EDGE_PULSE_EN
        , .rise(rise[1]), .fall(fall[1])
`endif
    );

    switch_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1000)) u_dut2 (
        .clk(clk), .rst(rst), .din(din), .dout(dout[2]), .busy(busy[2])
`ifdef DEBOUNCE_EDGE_PULSE_EN
        , .rise(rise[2]), .fall(fall[2])
`endif
    );

    // Reference: din is delayed by the sync depth; the accepted level flips once the
    // delayed input has disagreed with it for DEBOUNCE_CYCLES consecutive edges.
    int       m_ss [N] = '{2, 3, 3};
    int       m_dc [N] = '{4, 2, 1000};
    logic [3:0] m_sh [N];
    int       m_run [N];
    logic     m_dout [N];
    logic     m_busy [N];
    logic     m_rise [N];
    logic     m_fall [N];
    logic     m_s;

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!rst) begin
                m_sh[k]   = '0;
                m_run[k]  = 0;
                m_dout[k] = 1'b0;
                m_busy[k] = 1'b0;
                m_rise[k] = 1'b0;
                m_fall[k] = 1'b0;
            end else begin
                m_s       = m_sh[k][m_ss[k]-1];
                m_rise[k] = 1'b0;
                m_fall[k] = 1'b0;
                if (m_s != m_dout[k]) begin
                    m_run[k]++;
                    if (m_run[k] == m_dc[k]) begin
                        m_dout[k] = m_s;
                        m_rise[k] = m_s;
                        m_fall[k] = !m_s;
                        m_run[k]  = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_busy[k] = (m_run[k] != 0);
                m_sh[k]   = {m_sh[k][2:0], din};
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("model_dout[%0d]", k), dout[k], m_dout[k]);
            chk($sformatf("model_busy[%0d]", k), busy[k], m_busy[k]);
`ifdef DEBOUNCE_EDGE_PULSE_EN
            chk($sformatf("model_rise[%0d]", k), rise[k], m_rise[k]);
            chk($sformatf("model_fall[%0d]", k), fall[k], m_fall[k]);
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic rst;
        logic din;
        logic dout;
        logic busy;
        logic rise;
        logic fall;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic d, input logic o, input logic b,
                       input logic ri, input logic fa);
        vec_t v;
        v.rst = r; v.din = d; v.dout = o; v.busy = b; v.rise = ri; v.fall = fa;
        tbl.push_back(v);
    endtask

    int lat [N];
    int rise_cnt;
    int len;

    initial begin
        // Reset with din=1, then full-latency press (instance 0: 2 sync + 4 debounce)
        add(0,1,0,0,0,0); add(0,1,0,0,0,0); add(0,1,0,0,0,0);
        add(1,1,0,0,0,0); add(1,1,0,0,0,0); add(1,1,0,1,0,0);
        add(1,1,0,1,0,0); add(1,1,0,1,0,0); add(1,1,1,0,1,0);
        add(1,1,1,0,0,0);
        // 3-cycle 0-glitch in STABLE_HI
        add(1,0,1,0,0,0); add(1,0,1,0,0,0); add(1,0,1,1,0,0);
        add(1,1,1,1,0,0); add(1,1,1,1,0,0); add(1,1,1,0,0,0);
        add(1,1,1,0,0,0);
        // Clean release
        add(1,0,1,0,0,0); add(1,0,1,0,0,0); add(1,0,1,1,0,0);
        add(1,0,1,1,0,0); add(1,0,1,1,0,0); add(1,0,0,0,0,1);
        add(1,0,0,0,0,0);
        // 3-cycle 1-glitch in STABLE_LO
        add(1,1,0,0,0,0); add(1,1,0,0,0,0); add(1,1,0,1,0,0);
        add(1,0,0,1,0,0); add(1,0,0,1,0,0); add(1,0,0,0,0,0);
        add(1,0,0,0,0,0);
        // Reset on edge 4 of a press, din held 1 through release
        add(1,1,0,0,0,0); add(1,1,0,0,0,0); add(1,1,0,1,0,0);
        add(0,1,0,0,0,0); add(0,1,0,0,0,0);
        add(1,1,0,0,0,0); add(1,1,0,0,0,0); add(1,1,0,1,0,0);
        add(1,1,0,1,0,0); add(1,1,0,1,0,0); add(1,1,1,0,1,0);

        @(negedge clk);
        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            din = tbl[i].din;
            cycle();
            chk($sformatf("tbl%0d_dout", i), dout[0], tbl[i].dout);
            chk($sformatf("tbl%0d_busy", i), busy[0], tbl[i].busy);
`ifdef DEBOUNCE_EDGE_PULSE_EN
            chk($sformatf("tbl%0d_rise", i), rise[0], tbl[i].rise);
            chk($sformatf("tbl%0d_fall", i), fall[0], tbl[i].fall);
`endif
            check_model();
        end

        // Bounce then steady 1: measure latency of every configuration
        rst = 1'b0;
        din = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        rise_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            din = (i % 2 == 0);
            cycle();
            chk($sformatf("bounce%0d_dout0", i), dout[0], 1'b0);
            chk($sformatf("bounce%0d_dout1", i), dout[1], 1'b0);
`ifdef DEBOUNCE_EDGE_PULSE_EN
            if (rise[0]) rise_cnt++;
`endif
        end
        din = 1'b1;
        for (int k = 0; k < N; k++) lat[k] = 0;
        for (int e = 1; e <= 1100; e++) begin
            cycle();
            check_model();
`ifdef DEBOUNCE_EDGE_PULSE_EN
            if (rise[0]) rise_cnt++;
`endif
            for (int k = 0; k < N; k++)
                if (dout[k] === 1'b1 && lat[k] == 0) lat[k] = e;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
        end
        chk_int("latency_ss2_dc4", lat[0], 6);
        chk_int("latency_ss3_dc2", lat[1], 5);
        chk_int("latency_ss3_dc1000", lat[2], 1003);
`ifdef DEBOUNCE_EDGE_PULSE_EN
        chk_int("bounce_rise_count", rise_cnt, 1);
`endif

        // Randomized runs with occasional resets
        for (int c = 0; c < 2500; ) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                len = $urandom_range(1, 3);
            end else begin
                rst = 1'b1;
                din = $urandom_range(0, 1);
                len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 20)
                                                   : $urandom_range(1, 8);
            end
            for (int j = 0; j < len; j++) begin
                cycle();
                check_model();
                c++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
